zap_wb_mem_responder: RTL and testbench

- Wishbone classic single-access slave with a word-addressed RAM behind it.
- Serves the read and write cycles issued by the core's Wishbone initiators (TLB page-walk FSM, cache FSMs) during page-table walks and line fills.
- Inserts a programmable number of wait states, so initiator hold and ACK logic can be exercised under realistic memory latency.
- Returns a bus error for addresses outside its window.

---
 rtl/zap_wb_mem_responder_if.sv | 37 +++
 rtl/zap_wb_mem_responder.sv | 233 +++++++++++++++++++++++
 tb/tb_zap_wb_mem_responder.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zap_wb_mem_responder_if.sv
// ----------------------------------------------------------------------------
// zap_wb_mem_responder_if
//
// Wishbone classic single-access bus bundle between an initiator (master)
// and a memory responder (slave).
//
//   wb_cyc    master -> slave  bus cycle in progress
//   wb_stb    master -> slave  request strobe
//   wb_wen    master -> slave  1 = write, 0 = read
//   wb_sel    master -> slave  byte-lane enables, bit n covers [8n+7:8n]
//   wb_adr    master -> slave  byte address, bits [1:0] ignored
//   wb_dat_w  master -> slave  write data
//   wb_dat_r  slave -> master  read data, valid only while wb_ack is high
//   wb_ack    slave -> master  normal termination, one-cycle pulse
//   wb_err    slave -> master  error termination, one-cycle pulse
// ----------------------------------------------------------------------------
interface zap_wb_mem_responder_if;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_wen;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [31:0] wb_dat_r;
    logic        wb_ack;
    logic        wb_err;

    modport master (
        output wb_cyc, wb_stb, wb_wen, wb_sel, wb_adr, wb_dat_w,
        input  wb_dat_r, wb_ack, wb_err
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_wen, wb_sel, wb_adr, wb_dat_w,
        output wb_dat_r, wb_ack, wb_err
    );
endinterface

// File: rtl/zap_wb_mem_responder.sv
// ----------------------------------------------------------------------------
// zap_wb_mem_responder
//
// Wishbone classic single-access slave fronting a word-addressed RAM. Each
// accepted access is held for WAIT_STATES cycles before it is performed and
// terminated with a one-cycle ACK (in window) or ERR (outside the window), so
// initiators can be exercised against realistic memory latency.
//
// Parameters
//   DEPTH        number of 32-bit words, power of two
//   WAIT_STATES  idle cycles between acceptance and ACK/ERR (0..15)
//   BASE_ADDR    byte address of word 0, DEPTH*4 aligned
//
// Ports
//   i_clk    core clock, rising edge
//   i_reset  asynchronous, active-high reset
//   wb       Wishbone slave side (cyc/stb/wen/sel/adr/dat_w in,
//            dat_r/ack/err out; all outputs registered)
//   o_busy   high while an accepted access is outstanding
//
// Timing: request seen in cycle 0 -> ACK/ERR in cycle WAIT_STATES+1. After a
// response there is always at least one idle cycle before the next acceptance.
// ----------------------------------------------------------------------------
module zap_wb_mem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    zap_wb_mem_responder_if.slave        wb,
    output logic                         o_busy
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    // ------------------------------------------------------------------------
    // Address decode of the live request. A 33-bit subtraction gives the
    // "below BASE_ADDR" test as the borrow bit, and the window test reduces to
    // the offset bits above the word index being zero.
    // ------------------------------------------------------------------------
    logic [32:0]   off_full;
    logic [AW-1:0] req_idx;
    logic          req_in_range;
    logic          unused_off_bits;

    assign off_full        = {1'b0, wb.wb_adr} - {1'b0, BASE_ADDR};
    assign req_idx         = off_full[AW+1:2];
    assign req_in_range    = !off_full[32] && (off_full[31:AW+2] == '0);
    assign unused_off_bits = ^off_full[1:0];

    // ------------------------------------------------------------------------
    // State and latched request
    // ------------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          in_range_q, in_range_d;
    logic          wen_q, wen_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   dat_q, dat_d;
    logic          busy_q, busy_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [31:0]   rdat_q, rdat_d;

    // Access operands: with zero wait states the access happens on the
    // accepting edge, so the live request is used; otherwise the latched copy.
    logic [AW-1:0] acc_idx;
    logic          acc_in_range;
    logic          acc_wen;
    logic [3:0]    acc_sel;
    logic [31:0]   acc_dat;
    logic          do_access;
    logic          mem_we;

    logic [31:0]   mem [DEPTH];

    always_comb begin
        if (state_q == S_IDLE) begin
            acc_idx      = req_idx;
            acc_in_range = req_in_range;
            acc_wen      = wb.wb_wen;
            acc_sel      = wb.wb_sel;
            acc_dat      = wb.wb_dat_w;
        end else begin
            acc_idx      = idx_q;
            acc_in_range = in_range_q;
            acc_wen      = wen_q;
            acc_sel      = sel_q;
            acc_dat      = dat_q;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        in_range_d = in_range_q;
        wen_d      = wen_q;
        sel_d      = sel_q;
        dat_d      = dat_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rdat_d     = '0;
        do_access  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (wb.wb_cyc && wb.wb_stb) begin
                    idx_d      = req_idx;
                    in_range_d = req_in_range;
                    wen_d      = wb.wb_wen;
                    sel_d      = wb.wb_sel;
                    dat_d      = wb.wb_dat_w;
                    cnt_d      = WAIT_LOAD;
                    busy_d     = 1'b1;
                    if (WAIT_STATES == 0) begin
                        do_access = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        state_d   = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (!wb.wb_cyc) begin
                    // Initiator abandoned the cycle: no response, no write.
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        do_access = 1'b1;
                        state_d   = S_RESP;
                    end
                end
            end

            S_RESP: begin
                // stb still high here is deliberately ignored; the earliest
                // new acceptance is on the next edge out of IDLE.
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        if (do_access) begin
            if (acc_in_range) begin
                ack_d = 1'b1;
                if (!acc_wen) begin
                    rdat_d = mem[acc_idx];
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // A clock edge seen while reset is held must not commit a write.
    assign mem_we = do_access && acc_in_range && acc_wen && !i_reset;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            in_range_q <= 1'b0;
            wen_q      <= 1'b0;
            sel_q      <= '0;
            dat_q      <= '0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdat_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values regardless of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            in_range_q <= in_range_d;
            wen_q      <= wen_d;
            sel_q      <= sel_d;
            dat_q      <= dat_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdat_q     <= rdat_d;
        end
    end

    // NOTE: the RAM array has no reset; clearing it would prevent RAM
    // inference and its contents are defined only by writes.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_sel[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_dat[8*b +: 8];
                end
            end
        end
    end

    assign wb.wb_dat_r = rdat_q;
    assign wb.wb_ack   = ack_q;
    assign wb.wb_err   = err_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_zap_wb_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_zap_wb_mem_responder
//
// Four responders share one clock, reset and initiator bus; only the instance
// selected by `act` sees cyc/stb. Instance k has WAIT_STATES=k; instances 0-2
// map 1024 words at address 0, instance 3 maps 256 words at 0x2000.
// A transaction-level model predicts busy/ack/err/data for every instance on
// every cycle; directed accesses additionally pin literal latencies and data.
// ----------------------------------------------------------------------------
module tb_zap_wb_mem_responder;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // Shared initiator drive
    int          act;
    logic        d_cyc, d_stb, d_wen;
    logic [3:0]  d_sel;
    logic [31:0] d_adr, d_dat;

    // Per-instance observed outputs
    logic [N-1:0] ack_w, err_w, busy_w;
    logic [31:0]  dat_w [N];

    for (genvar k = 0; k < N; k++) begin : g_dut
        localparam int unsigned DP = (k == 3) ? 256 : 1024;
        localparam logic [31:0] BA = (k == 3) ? 32'h0000_2000 : 32'h0000_0000;

        zap_wb_mem_responder_if wb ();

        assign wb.wb_cyc   = d_cyc && (act == k);
        assign wb.wb_stb   = d_stb && (act == k);
        assign wb.wb_wen   = d_wen;
        assign wb.wb_sel   = d_sel;
        assign wb.wb_adr   = d_adr;
        assign wb.wb_dat_w = d_dat;

        zap_wb_mem_responder #(
            .DEPTH       (DP),
            .WAIT_STATES (k),
            .BASE_ADDR   (BA)
        ) dut (
            .i_clk   (clk),
            .i_reset (rst),
            .wb      (wb),
            .o_busy  (busy_w[k])
        );

        assign ack_w[k] = wb.wb_ack;
        assign err_w[k] = wb.wb_err;
        assign dat_w[k] = wb.wb_dat_r;
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp, input logic [31:0] mask);
        n_vec++;
        if (((got ^ exp) & mask) !== 32'h0) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (mask %08h)", name, got, exp, mask);
        end
    endtask

    // ------------------------------------------------------------------------
    // Transaction-level model
    // ------------------------------------------------------------------------
    function automatic longint unsigned depth_of(input int k);
        return (k == 3) ? 64'd256 : 64'd1024;
    endfunction

    function automatic longint unsigned base_of(input int k);
        return (k == 3) ? 64'h2000 : 64'h0;
    endfunction

    int          cyc_n = 0;            // index of the current clock cycle
    bit          tv      [N];          // a transaction has been recorded
    int          t_start [N];          // first busy cycle
    int          t_end   [N];          // response cycle
    int          t_cut   [N];          // last busy cycle (earlier if aborted)
    bit          t_in    [N];
    int          t_idx   [N];
    bit          t_wen   [N];
    logic [3:0]  t_sel   [N];
    logic [31:0] t_dat   [N];
    bit          t_err   [N];
    logic [31:0] t_rdata [N];
    logic [31:0] t_rmask [N];
    logic [31:0] mram    [N][1024];
    logic [31:0] mknown  [N][1024];    // bits that hold a written value

    initial begin
        for (int k = 0; k < N; k++) begin
            tv[k] = 1'b0;
            for (int i = 0; i < 1024; i++) begin
                mram[k][i]   = '0;
                mknown[k][i] = '0;
            end
        end
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int k = 0; k < N; k++) tv[k] = 1'b0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    bit                ck, sk, bz;
                    longint unsigned   a;
                    ck = d_cyc && (act == k);
                    sk = d_stb && (act == k);
                    a  = {32'h0, d_adr};
                    bz = tv[k] && (cyc_n >= t_start[k]) && (cyc_n <= t_cut[k]);
                    if (bz) begin
                        if ((cyc_n < t_end[k]) && !ck) t_cut[k] = cyc_n;
                    end else if (ck && sk) begin
                        tv[k]      = 1'b1;
                        t_start[k] = cyc_n + 1;
                        t_end[k]   = cyc_n + 1 + k;
                        t_cut[k]   = t_end[k];
                        t_in[k]    = (a >= base_of(k)) && (((a - base_of(k)) / 4) < depth_of(k));
                        t_idx[k]   = t_in[k] ? int'((a - base_of(k)) / 4) : 0;
                        t_wen[k]   = d_wen;
                        t_sel[k]   = d_sel;
                        t_dat[k]   = d_dat;
                    end
                    // The access is performed on the edge that enters the
                    // response cycle, provided the cycle was not abandoned.
                    if (tv[k] && (t_cut[k] == t_end[k]) && (cyc_n == t_end[k] - 1)) begin
                        if (!t_in[k]) begin
                            t_err[k]   = 1'b1;
                            t_rdata[k] = '0;
                            t_rmask[k] = '1;
                        end else if (t_wen[k]) begin
                            t_err[k] = 1'b0;
                            for (int b = 0; b < 4; b++) begin
                                if (t_sel[k][b]) begin
                                    mram[k][t_idx[k]][8*b +: 8]   = t_dat[k][8*b +: 8];
                                    mknown[k][t_idx[k]][8*b +: 8] = 8'hFF;
                                end
                            end
                            t_rdata[k] = '0;
                            t_rmask[k] = '0;
                        end else begin
                            t_err[k]   = 1'b0;
                            t_rdata[k] = mram[k][t_idx[k]];
                            t_rmask[k] = mknown[k][t_idx[k]];
                        end
                    end
                end
            end
            cyc_n++;
        end
    end

    // Compare every instance against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                logic        eb, ea, ee, resp;
                logic [31:0] ed, em;
                if (rst) begin
                    eb = 1'b0; ea = 1'b0; ee = 1'b0; ed = '0; em = '1;
                end else begin
                    resp = tv[k] && (t_cut[k] == t_end[k]) && (cyc_n == t_end[k]);
                    eb   = tv[k] && (cyc_n >= t_start[k]) && (cyc_n <= t_cut[k]);
                    ea   = resp && !t_err[k];
                    ee   = resp && t_err[k];
                    ed   = resp ? t_rdata[k] : 32'h0;
                    em   = resp ? t_rmask[k] : 32'hFFFF_FFFF;
                end
                check($sformatf("busy[%0d]@%0d", k, cyc_n), {31'h0, busy_w[k]}, {31'h0, eb}, 32'h1);
                check($sformatf("ack[%0d]@%0d",  k, cyc_n), {31'h0, ack_w[k]},  {31'h0, ea}, 32'h1);
                check($sformatf("err[%0d]@%0d",  k, cyc_n), {31'h0, err_w[k]},  {31'h0, ee}, 32'h1);
                check($sformatf("dat[%0d]@%0d",  k, cyc_n), dat_w[k], ed, em);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    // Presents a request in the current cycle (cycle 0) and waits for ACK/ERR.
    // lat is the cycle index in which the response was seen. With scramble,
    // stb/adr/dat/wen/sel are changed in cycle 1 while cyc stays high. With
    // hold, cyc/stb are left high on return (the response cycle).
    task automatic access(input int k, input bit wen, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel,
                          input bit scramble, input bit hold,
                          output logic [31:0] rdat, output int lat, output bit got_err);
        bit done;
        done    = 1'b0;
        lat     = 0;
        rdat    = '0;
        got_err = 1'b0;
        act   = k;
        d_cyc = 1'b1;
        d_stb = 1'b1;
        d_wen = wen;
        d_adr = adr;
        d_dat = dat;
        d_sel = sel;
        for (int c = 1; c <= 24 && !done; c++) begin
            @(posedge clk);
            #2;
            if (scramble && c == 1) begin
                d_stb = 1'b0;
                d_adr = ~adr;
                d_dat = ~dat;
                d_wen = !wen;
                d_sel = ~sel;
            end
            if (ack_w[k] || err_w[k]) begin
                done    = 1'b1;
                lat     = c;
                rdat    = dat_w[k];
                got_err = err_w[k];
            end
        end
        if (!done) check($sformatf("timeout[%0d] adr %08h", k, adr), 32'h0, 32'h1, '1);
        if (!hold) begin
            d_cyc = 1'b0;
            d_stb = 1'b0;
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        bit          er;

        rst   = 1'b1;
        act   = 0;
        d_cyc = 1'b0;
        d_stb = 1'b0;
        d_wen = 1'b0;
        d_sel = '0;
        d_adr = '0;
        d_dat = '0;
        repeat (2) @(posedge clk);
        #2;
        for (int k = 0; k < N; k++) begin
            check($sformatf("reset_flags[%0d]", k), {29'h0, busy_w[k], ack_w[k], err_w[k]}, 32'h0, '1);
            check($sformatf("reset_dat[%0d]", k), dat_w[k], 32'h0, '1);
        end
        rst = 1'b0;

        // Preload through the bus
        access(1, 1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, rd, lat, er);
        access(1, 1'b1, 32'h0000_0000, 32'h0000_0402, 4'hF, 1'b0, 1'b0, rd, lat, er);
        access(1, 1'b1, 32'h0000_0010, 32'hABCD_E00E, 4'hF, 1'b0, 1'b0, rd, lat, er);
        access(0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0, rd, lat, er);
        access(2, 1'b1, 32'h0000_001C, 32'h1234_5678, 4'hF, 1'b0, 1'b0, rd, lat, er);
        access(3, 1'b1, 32'h0000_2008, 32'h5555_AAAA, 4'hF, 1'b0, 1'b0, rd, lat, er);
        check("preload_ws3_lat", lat, 32'd4, '1);

        // One wait state read; request lines scrambled after acceptance
        access(1, 1'b0, 32'h0000_0014, 32'h0, 4'h0, 1'b1, 1'b0, rd, lat, er);
        check("t1_lat", lat, 32'd2, '1);
        check("t1_data", rd, 32'hDEAD_BEEF, '1);

        // Zero wait states, partial-lane write then readback
        access(0, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'b0101, 1'b0, 1'b0, rd, lat, er);
        check("t2_wr_lat", lat, 32'd1, '1);
        access(0, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 1'b0, 1'b0, rd, lat, er);
        check("t2_rd_lat", lat, 32'd1, '1);
        check("t2_data", rd, 32'hFF22_FF44, '1);

        // Just past the window: error, no aliasing onto word 0
        access(1, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 1'b0, 1'b0, rd, lat, er);
        check("t3_rd_err", {31'h0, er}, 32'h1, '1);
        check("t3_rd_dat", rd, 32'h0, '1);
        access(1, 1'b1, 32'h0000_1000, 32'h0BAD_0BAD, 4'hF, 1'b0, 1'b0, rd, lat, er);
        check("t3_wr_err", {31'h0, er}, 32'h1, '1);
        access(1, 1'b0, 32'h0000_0000, 32'h0, 4'hF, 1'b0, 1'b0, rd, lat, er);
        check("t3_word0", rd, 32'h0000_0402, '1);

        // Three wait states, cyc dropped in cycle 2
        act   = 3;
        d_cyc = 1'b1;
        d_stb = 1'b1;
        d_wen = 1'b1;
        d_adr = 32'h0000_2008;
        d_dat = 32'h0000_0000;
        d_sel = 4'hF;
        @(posedge clk); #2;
        d_stb = 1'b0;
        @(posedge clk); #2;
        d_cyc = 1'b0;
        @(posedge clk); #2;
        check("t4_busy_c3", {31'h0, busy_w[3]}, 32'h0, '1);
        repeat (5) @(posedge clk);
        #2;
        access(3, 1'b0, 32'h0000_2008, 32'h0, 4'hF, 1'b0, 1'b0, rd, lat, er);
        check("t4_ram2", rd, 32'h5555_AAAA, '1);

        // Two wait states, reset asserted in cycle 2 of a write
        act   = 2;
        d_cyc = 1'b1;
        d_stb = 1'b1;
        d_wen = 1'b1;
        d_adr = 32'h0000_001C;
        d_dat = 32'h0000_0000;
        d_sel = 4'hF;
        @(posedge clk); #2;
        d_stb = 1'b0;
        @(posedge clk); #2;
        rst   = 1'b1;
        d_cyc = 1'b0;
        #1;
        check("t5_async_flags", {29'h0, busy_w[2], ack_w[2], err_w[2]}, 32'h0, '1);
        check("t5_async_dat", dat_w[2], 32'h0, '1);
        @(posedge clk); #2;
        rst = 1'b0;
        access(2, 1'b0, 32'h0000_001C, 32'h0, 4'hF, 1'b0, 1'b0, rd, lat, er);
        check("t5_lat", lat, 32'd3, '1);
        check("t5_data", rd, 32'h1234_5678, '1);

        // Page walk: L2 request presented while L1 response is on the bus
        access(1, 1'b0, 32'h0000_0000, 32'h0, 4'hF, 1'b0, 1'b1, rd, lat, er);
        check("t6_l1_lat", lat, 32'd2, '1);
        check("t6_l1_data", rd, 32'h0000_0402, '1);
        access(1, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0, 1'b0, rd, lat, er);
        check("t6_l2_lat", lat, 32'd3, '1);
        check("t6_l2_data", rd, 32'hABCD_E00E, '1);

        // Window boundaries of the based instance
        access(3, 1'b0, 32'h0000_1FFC, 32'h0, 4'hF, 1'b0, 1'b0, rd, lat, er);
        check("bnd_below", {31'h0, er}, 32'h1, '1);
        access(3, 1'b0, 32'h0000_2400, 32'h0, 4'hF, 1'b0, 1'b0, rd, lat, er);
        check("bnd_above", {31'h0, er}, 32'h1, '1);
        access(3, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 1'b0, 1'b0, rd, lat, er);
        check("bnd_top", {31'h0, er}, 32'h1, '1);
        access(3, 1'b1, 32'h0000_23FF, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, rd, lat, er);
        check("bnd_last_wr", {31'h0, er}, 32'h0, '1);
        access(3, 1'b0, 32'h0000_23FC, 32'h0, 4'hF, 1'b0, 1'b0, rd, lat, er);
        check("bnd_last_rd", rd, 32'hCAFE_F00D, '1);

        repeat (3) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
